data_memory_latency: RTL

- Parametrised successor to the single-cycle data memory.
- Word-organised RAM with byte-enable writes, a configurable multi-cycle access latency, a req/ready/done handshake, and a stall output that freezes the CPU pipeline while an access is in flight.
- Flags misaligned and out-of-range accesses instead of wrapping them silently.
- Sits in the MEM stage between the ALU result/RS2 data and the write-back mux.

---
 rtl/data_memory_latency.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_memory_latency.sv
// Word RAM with byte-enable writes, fixed multi-cycle latency and a
// req/ready/done handshake. Ports: clk_i, rst_i, req_i, we_i, addr_i,
// wdata_i, be_i in; ready_o, done_o, rdata_o, err_o, stall_o out.
module data_memory_latency #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic                ready_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                stall_o
);

  localparam int NB    = DATA_W / 8;
  localparam int SHIFT = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic              err_q;

  logic [ADDR_W-1:0] word_addr;
  logic              req_err;
  logic              accept;
  logic              finish;

  logic              op_we;
  logic [IDX_W-1:0]  op_idx;
  logic [DATA_W-1:0] op_wdata;
  logic [NB-1:0]     op_be;
  logic              op_err;

  assign word_addr = addr_i >> SHIFT;
  assign req_err   = (|(addr_i & OFF_MASK)) ||
                     (word_addr >= DEPTH_A);
  assign accept    = ready_o && req_i;

  // With LATENCY=1 an access completes on its own accept edge,
  // so the live inputs are used instead of the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = we_i;
      op_idx   = word_addr[IDX_W-1:0];
      op_wdata = wdata_i;
      op_be    = be_i;
      op_err   = req_err;
    end else begin
      op_we    = we_q;
      op_idx   = idx_q;
      op_wdata = wdata_q;
      op_be    = be_q;
      op_err   = err_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    ready_o = 1'b0;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        stall_o = req_i;
        if (req_i) begin
          if (LATENCY == 1) begin
            finish = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      idx_q   <= word_addr[IDX_W-1:0];
      wdata_q <= wdata_i;
      be_q    <= be_i;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      done_o <= finish;
      err_o  <= finish && op_err;
      if (finish && (op_err || !op_we))
        rdata_o <= op_err ? '0 : mem[op_idx];
    end
  end

  // Array is never cleared; reset only blocks a pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && finish && op_we && !op_err) begin
      for (int k = 0; k < NB; k++) begin
        if (op_be[k])
          mem[op_idx][8*k +: 8] <= op_wdata[8*k +: 8];
      end
    end
  end

endmodule
